// File: rtl/param_stack.sv
// Parametrised LIFO with full/count status, sticky overflow/underflow flags and replace-top on push+pop.
// One-cycle pop latency (registered data_out/pop_valid); no backpressure: rejected pushes/pops only set the sticky flags.
module param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear_err,
    output logic [WIDTH-1:0] data_out,
    output logic             pop_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             pop_valid_q, pop_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    free_idx;
    logic             empty_w;
    logic             full_w;

    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == CW'(DEPTH));
    assign top_idx  = AW'(count_q - CW'(1));
    assign free_idx = AW'(count_q);

    always_comb begin
        count_d     = count_q;
        data_out_d  = data_out_q;
        pop_valid_d = 1'b0;
        overflow_d  = clear_err ? 1'b0 : overflow_q;
        underflow_d = clear_err ? 1'b0 : underflow_q;
        mem_we      = 1'b0;
        mem_waddr   = free_idx;

        unique case ({push, pop})
            2'b10: begin
                if (full_w) begin
                    overflow_d = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = free_idx;
                    count_d   = count_q + CW'(1);
                end
            end
            2'b01: begin
                if (empty_w) begin
                    underflow_d = 1'b1;
                end else begin
                    data_out_d  = mem_q[top_idx];
                    pop_valid_d = 1'b1;
                    count_d     = count_q - CW'(1);
                end
            end
            2'b11: begin
                // Replace-top keeps the depth constant; on an empty stack the word passes straight through.
                pop_valid_d = 1'b1;
                if (empty_w) begin
                    data_out_d = data_in;
                end else begin
                    data_out_d = mem_q[top_idx];
                    mem_we     = 1'b1;
                    mem_waddr  = top_idx;
                end
            end
            default: begin
            end
        endcase

        // Reset dominates every other request, including the memory write.
        if (reset) begin
            count_d     = '0;
            data_out_d  = '0;
            pop_valid_d = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            mem_we      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        count_q     <= count_d;
        data_out_q  <= data_out_d;
        pop_valid_q <= pop_valid_d;
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign pop_valid = pop_valid_q;
    assign count     = count_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack at WIDTH=8, DEPTH=4.
module tb_param_stack;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic       clear_err;
    logic [7:0] data_out;
    logic       pop_valid;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    param_stack #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .data_in   (data_in),
        .clear_err (clear_err),
        .data_out  (data_out),
        .pop_valid (pop_valid),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 0; pop = 0; clear_err = 0; reset = 0;
    endtask

    task automatic do_push(input logic [7:0] d);
        idle(); push = 1; data_in = d; tick(); idle();
    endtask

    task automatic do_pop();
        idle(); pop = 1; tick(); idle();
    endtask

    task automatic test_reset();
        idle(); data_in = 8'h00; reset = 1; tick(); tick(); idle();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
        checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL reset_pv got=%b exp=0", pop_valid); end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {overflow, underflow}); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp_pop [4];
        exp_pop = '{8'h44, 8'h33, 8'h22, 8'h11};
        do_push(8'h11); do_push(8'h22); do_push(8'h33); do_push(8'h44);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (full !== 1'b1 || empty !== 1'b0) begin failures++; $display("FAIL fill_flags got full=%b empty=%b exp full=1 empty=0", full, empty); end
        for (int i = 0; i < 4; i++) begin
            do_pop();
            checks++; if (data_out !== exp_pop[i] || pop_valid !== 1'b1) begin
                failures++; $display("FAIL drain_%0d got=%h/%b exp=%h/1", i, data_out, pop_valid, exp_pop[i]);
            end
        end
        checks++; if (empty !== 1'b1 || count !== 3'd0) begin failures++; $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", empty, count); end
        tick();
        checks++; if (pop_valid !== 1'b0 || data_out !== 8'h11) begin failures++; $display("FAIL idle_hold got=%h/%b exp=11/0", data_out, pop_valid); end
    endtask

    task automatic test_overflow();
        do_push(8'h11); do_push(8'h22); do_push(8'h33); do_push(8'h44);
        do_push(8'h55);
        checks++; if (overflow !== 1'b1 || count !== 3'd4) begin failures++; $display("FAIL ovf_set got ovf=%b count=%0d exp 1/4", overflow, count); end
        do_pop();
        checks++; if (data_out !== 8'h44 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_pop got=%h ovf=%b exp=44 ovf=1", data_out, overflow); end
        idle(); clear_err = 1; tick(); idle();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        do_pop(); do_pop(); do_pop();
        checks++; if (data_out !== 8'h11 || count !== 3'd0) begin failures++; $display("FAIL ovf_drain got=%h count=%0d exp=11/0", data_out, count); end
    endtask

    task automatic test_underflow();
        do_pop();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_set got=%b exp=1", underflow); end
        checks++; if (pop_valid !== 1'b0 || data_out !== 8'h11 || count !== 3'd0) begin
            failures++; $display("FAIL unf_hold got=%h/%b count=%0d exp=11/0 count=0", data_out, pop_valid, count);
        end
        idle(); pop = 1; clear_err = 1; tick(); idle();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_set_wins got=%b exp=1", underflow); end
        idle(); clear_err = 1; tick(); idle();
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b exp=0", underflow); end
    endtask

    task automatic test_replace_top();
        do_push(8'h11); do_push(8'h22);
        idle(); push = 1; pop = 1; data_in = 8'hAA; tick(); idle();
        checks++; if (data_out !== 8'h22 || pop_valid !== 1'b1 || count !== 3'd2) begin
            failures++; $display("FAIL repl_top got=%h/%b count=%0d exp=22/1 count=2", data_out, pop_valid, count);
        end
        do_pop();
        checks++; if (data_out !== 8'hAA || count !== 3'd1) begin failures++; $display("FAIL repl_next got=%h count=%0d exp=AA/1", data_out, count); end
        do_pop();
        checks++; if (data_out !== 8'h11 || count !== 3'd0) begin failures++; $display("FAIL repl_last got=%h count=%0d exp=11/0", data_out, count); end
    endtask

    task automatic test_pass_through();
        idle(); push = 1; pop = 1; data_in = 8'h5A; tick(); idle();
        checks++; if (data_out !== 8'h5A || pop_valid !== 1'b1) begin failures++; $display("FAIL pass_data got=%h/%b exp=5A/1", data_out, pop_valid); end
        checks++; if (count !== 3'd0 || underflow !== 1'b0 || empty !== 1'b1) begin
            failures++; $display("FAIL pass_state got count=%0d unf=%b empty=%b exp 0/0/1", count, underflow, empty);
        end
    endtask

    task automatic test_full_replace();
        do_push(8'h11); do_push(8'h22); do_push(8'h33); do_push(8'h44);
        idle(); push = 1; pop = 1; data_in = 8'h99; tick(); idle();
        checks++; if (data_out !== 8'h44 || count !== 3'd4 || overflow !== 1'b0) begin
            failures++; $display("FAIL full_repl got=%h count=%0d ovf=%b exp=44/4/0", data_out, count, overflow);
        end
        do_pop();
        checks++; if (data_out !== 8'h99 || count !== 3'd3) begin failures++; $display("FAIL full_repl_pop got=%h count=%0d exp=99/3", data_out, count); end
    endtask

    task automatic test_reset_dominates();
        do_push(8'h66); do_push(8'h77); do_pop();
        checks++; if (count !== 3'd3 || overflow !== 1'b1 || data_out !== 8'h66) begin
            failures++; $display("FAIL pre_reset got count=%0d ovf=%b data=%h exp 3/1/66", count, overflow, data_out);
        end
        idle(); reset = 1; push = 1; data_in = 8'h88; tick(); idle();
        checks++; if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
            failures++; $display("FAIL rst_dom_state got count=%0d empty=%b ovf=%b exp 0/1/0", count, empty, overflow);
        end
        checks++; if (data_out !== 8'h00 || pop_valid !== 1'b0) begin failures++; $display("FAIL rst_dom_out got=%h/%b exp=00/0", data_out, pop_valid); end
        tick();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_dom_push_ignored got=%0d exp=0", count); end
    endtask

    initial begin
        idle();
        data_in = 8'h00;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_replace_top();
        test_pass_through();
        test_full_replace();
        test_reset_dominates();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
